// File: rtl/box_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : box_renderer_if
// Purpose  : Sync-generator inputs, control inputs and pixel/box outputs of
//            the bouncing-box renderer, bundled for one connection.
// Revision : 1.0
// ============================================================================
interface box_renderer_if;
  logic       Horizontal_sync;
  logic       Vertical_sync;
  logic [9:0] currentRow;
  logic [9:0] currentColumn;
  logic       pause;
  logic [1:0] speed;
  logic       hsync_out;
  logic       vsync_out;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       frame_tick;

  modport master (
    output Horizontal_sync, Vertical_sync, currentRow, currentColumn, pause, speed,
    input  hsync_out, vsync_out, red, green, blue, box_x, box_y, frame_tick
  );

  modport slave (
    input  Horizontal_sync, Vertical_sync, currentRow, currentColumn, pause, speed,
    output hsync_out, vsync_out, red, green, blue, box_x, box_y, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/box_renderer.sv
`default_nettype none
// ============================================================================
// Module   : box_renderer
// Purpose  : Two-stage pixel pipeline drawing a bordered screen with a
//            bouncing square, moved once per frame during vertical blanking.
// Revision : 1.0
// ============================================================================
module box_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  box_renderer_if.slave bus
);

  localparam logic [9:0]  c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0]  c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0]  c_h_last   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  c_v_last   = 10'(V_ACTIVE - 1);
  localparam logic [10:0] c_box_size = 11'(BOX_SIZE);
  localparam logic [10:0] c_x_max    = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_y_max    = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  c_x_init   = 10'((H_ACTIVE - BOX_SIZE) / 2);
  localparam logic [9:0]  c_y_init   = 10'((V_ACTIVE - BOX_SIZE) / 2);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_PAUSED = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_pause_prev;
  logic       w_pause_rise;

  logic       r_hs1, r_vs1, r_active1, r_border1, r_inbox1;
  logic       r_hs2, r_vs2;
  logic [3:0] r_red, r_green, r_blue;
  logic       r_tick;
  logic [9:0] r_box_x, r_box_y;
  logic       r_dx, r_dy;

  logic       w_active, w_border, w_inbox;
  logic [10:0] w_col11, w_row11;
  logic [10:0] w_step;
  logic [10:0] w_sum_x, w_sum_y;
  logic [9:0]  w_next_x, w_next_y;
  logic        w_next_dx, w_next_dy;

  // Pixel classification on the raw sync-generator coordinates
  assign w_col11  = {1'b0, bus.currentColumn};
  assign w_row11  = {1'b0, bus.currentRow};
  assign w_active = (bus.currentColumn < c_h_active) && (bus.currentRow < c_v_active);
  assign w_border = (bus.currentColumn == 10'd0) || (bus.currentColumn == c_h_last) ||
                    (bus.currentRow == 10'd0)    || (bus.currentRow == c_v_last);
  assign w_inbox  = (w_col11 >= {1'b0, r_box_x}) && (w_col11 < ({1'b0, r_box_x} + c_box_size)) &&
                    (w_row11 >= {1'b0, r_box_y}) && (w_row11 < ({1'b0, r_box_y} + c_box_size));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_active1 <= 1'b0;
      r_border1 <= 1'b0;
      r_inbox1  <= 1'b0;
    end else begin
      r_hs1     <= bus.Horizontal_sync;
      r_vs1     <= bus.Vertical_sync;
      r_active1 <= w_active;
      r_border1 <= w_border;
      r_inbox1  <= w_inbox;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_red   <= 4'h0;
      r_green <= 4'h0;
      r_blue  <= 4'h0;
    end else begin
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      if (!r_active1) begin
        {r_red, r_green, r_blue} <= 12'h000;
      end else if (r_inbox1) begin
        {r_red, r_green, r_blue} <= 12'hF00;
      end else if (r_border1) begin
        {r_red, r_green, r_blue} <= 12'hFFF;
      end else begin
        {r_red, r_green, r_blue} <= 12'h004;
      end
    end
  end

  // Tick fires one cycle after the first blanking line starts, so the box
  // only ever moves while nothing visible is being drawn.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= (bus.currentRow == c_v_active) && (bus.currentColumn == 10'd0);
    end
  end

  assign w_pause_rise = bus.pause && !r_pause_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_pause_prev <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pause_prev <= bus.pause;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_pause_rise) begin
      w_state_next = (r_state == S_RUN) ? S_PAUSED : S_RUN;
    end
  end

  // Bounce arithmetic in 11 bits so the sums never wrap
  always_comb begin
    w_step    = {8'd0, ({1'b0, bus.speed} + 3'd1)};
    w_sum_x   = {1'b0, r_box_x} + w_step;
    w_sum_y   = {1'b0, r_box_y} + w_step;
    w_next_x  = r_box_x;
    w_next_y  = r_box_y;
    w_next_dx = r_dx;
    w_next_dy = r_dy;
    if (!r_dx) begin
      if (w_sum_x >= c_x_max) begin
        w_next_x  = c_x_max[9:0];
        w_next_dx = 1'b1;
      end else begin
        w_next_x  = w_sum_x[9:0];
      end
    end else if ({1'b0, r_box_x} <= w_step) begin
      w_next_x  = 10'd0;
      w_next_dx = 1'b0;
    end else begin
      w_next_x  = r_box_x - w_step[9:0];
    end
    if (!r_dy) begin
      if (w_sum_y >= c_y_max) begin
        w_next_y  = c_y_max[9:0];
        w_next_dy = 1'b1;
      end else begin
        w_next_y  = w_sum_y[9:0];
      end
    end else if ({1'b0, r_box_y} <= w_step) begin
      w_next_y  = 10'd0;
      w_next_dy = 1'b0;
    end else begin
      w_next_y  = r_box_y - w_step[9:0];
    end
  end

  // Uses the pre-toggle state, so a pause edge on the tick still moves once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_box_x <= c_x_init;
      r_box_y <= c_y_init;
      r_dx    <= 1'b0;
      r_dy    <= 1'b0;
    end else if (r_tick && (r_state == S_RUN)) begin
      r_box_x <= w_next_x;
      r_box_y <= w_next_y;
      r_dx    <= w_next_dx;
      r_dy    <= w_next_dy;
    end
  end

  assign bus.hsync_out  = r_hs2;
  assign bus.vsync_out  = r_vs2;
  assign bus.red        = r_red;
  assign bus.green      = r_green;
  assign bus.blue       = r_blue;
  assign bus.box_x      = r_box_x;
  assign bus.box_y      = r_box_y;
  assign bus.frame_tick = r_tick;

endmodule
`default_nettype wire
